// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program-counter sequencer with conditional
//   branches, CALL/RET through a hardware return-address stack, stall and
//   a sticky error flag. Sits between the controller and the instruction ROM.
// Latency: one cycle; the new pc, taken and stack state are visible after the edge.
// Backpressure: en=0 stalls; pc, stack and err hold and taken drops to 0.
//
// Optional feature: define PC_TRACE_EN to add last_src/last_dst, which
// capture the pre-redirect pc and the new pc on every redirecting cycle.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high reset (overrides en and op)
//   en           advance enable; 0 = stall
//   op           000 NEXT, 001 JMP, 010 JCOND, 011 CALL, 100 RET, others NEXT
//   cond_sel     00 always, 01 carry, 10 zero, 11 never (JCOND only)
//   cond_inv     invert the selected condition (JCOND only)
//   carry_f      ALU carry flag, sampled in the same cycle as op
//   zero_f       ALU zero flag, sampled in the same cycle as op
//   target       branch / call destination
//   pc           current program counter (registered)
//   taken        1 if the previous enabled cycle redirected the pc
//   stack_depth  occupied return-stack entries
//   stack_full   stack_depth == DEPTH
//   stack_empty  stack_depth == 0
//   err          sticky: CALL on full or RET on empty; cleared by reset only
//   last_src     (PC_TRACE_EN) pc before the most recent redirect
//   last_dst     (PC_TRACE_EN) pc after the most recent redirect

module pc_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter int                STEP       = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                DEPTH      = 4,
    localparam int               DEPTH_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [2:0]         op,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic               carry_f,
    input  logic               zero_f,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc,
    output logic               taken,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               err
`ifdef PC_TRACE_EN
    ,
    output logic [ADDR_W-1:0]  last_src,
    output logic [ADDR_W-1:0]  last_dst
`endif
);

    // Index width into the stack storage; a single-entry stack still
    // needs a one-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'b000,
        OP_JMP   = 3'b001,
        OP_JCOND = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_CARRY  = 2'b01,
        COND_ZERO   = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

    // Return-address storage. Contents are don't-care after reset; only
    // stack_depth decides which entries are live.
    logic [ADDR_W-1:0] stack_mem [DEPTH];

    logic [ADDR_W-1:0]  seq;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               taken_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               err_nxt;
    logic               push;
    logic               cond_raw;
    logic               cond_hit;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;

    // Sequential successor; wrapping past the top of the address space is
    // legal and silent.
    assign seq = pc + ADDR_W'(STEP);

    assign stack_full  = (stack_depth == DEPTH_W'(DEPTH));
    assign stack_empty = (stack_depth == '0);

    // push_idx is only used when not full and pop_idx only when not empty,
    // so truncation to IDX_W never aliases a live entry.
    assign push_idx = IDX_W'(stack_depth);
    assign pop_idx  = IDX_W'(stack_depth - DEPTH_W'(1));

    // Branch condition: flags come straight from the ALU in the same cycle.
    always_comb begin
        cond_raw = 1'b0;
        case (cond_sel)
            COND_ALWAYS: cond_raw = 1'b1;
            COND_CARRY:  cond_raw = carry_f;
            COND_ZERO:   cond_raw = zero_f;
            COND_NEVER:  cond_raw = 1'b0;
            default:     cond_raw = 1'b0;
        endcase
        cond_hit = cond_raw ^ cond_inv;
    end

    // Next-state decode. Failed CALL/RET fall through to the sequential pc
    // so the core keeps fetching while err flags the fault.
    always_comb begin
        pc_nxt    = pc;
        taken_nxt = 1'b0;
        depth_nxt = stack_depth;
        err_nxt   = err;
        push      = 1'b0;

        if (en) begin
            pc_nxt = seq;
            case (op)
                OP_JMP: begin
                    pc_nxt    = target;
                    taken_nxt = 1'b1;
                end
                OP_JCOND: begin
                    if (cond_hit) begin
                        pc_nxt    = target;
                        taken_nxt = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (stack_full) begin
                        err_nxt = 1'b1;
                    end else begin
                        push      = 1'b1;
                        depth_nxt = stack_depth + DEPTH_W'(1);
                        pc_nxt    = target;
                        taken_nxt = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        err_nxt = 1'b1;
                    end else begin
                        depth_nxt = stack_depth - DEPTH_W'(1);
                        pc_nxt    = stack_mem[pop_idx];
                        taken_nxt = 1'b1;
                    end
                end
                default: begin
                    // NEXT and unused encodings: sequential advance.
                    pc_nxt = seq;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            taken       <= 1'b0;
            stack_depth <= '0;
            err         <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            taken       <= taken_nxt;
            stack_depth <= depth_nxt;
            err         <= err_nxt;
        end
    end

    // Storage has no reset; a push is suppressed while reset is high so a
    // CALL presented alongside reset leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_mem[push_idx] <= seq;
        end
    end

`ifdef PC_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_src <= RESET_ADDR;
            last_dst <= RESET_ADDR;
        end else if (taken_nxt) begin
            last_src <= pc;
            last_dst <= pc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int          ADDR_W     = 8;
    localparam int          STEP       = 2;
    localparam int          DEPTH      = 4;
    localparam logic [7:0]  RESET_ADDR = 8'h00;

    localparam logic [2:0] NEXT  = 3'd0;
    localparam logic [2:0] JMP   = 3'd1;
    localparam logic [2:0] JCOND = 3'd2;
    localparam logic [2:0] CALL  = 3'd3;
    localparam logic [2:0] RET   = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic [1:0]  cond_sel;
    logic        cond_inv;
    logic        carry_f;
    logic        zero_f;
    logic [7:0]  target;
    logic [7:0]  pc;
    logic        taken;
    logic [2:0]  stack_depth;
    logic        stack_full;
    logic        stack_empty;
    logic        err;
`ifdef PC_TRACE_EN
    logic [7:0]  last_src;
    logic [7:0]  last_dst;
`endif

    pc_sequencer #(
        .ADDR_W     (ADDR_W),
        .STEP       (STEP),
        .RESET_ADDR (RESET_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .op          (op),
        .cond_sel    (cond_sel),
        .cond_inv    (cond_inv),
        .carry_f     (carry_f),
        .zero_f      (zero_f),
        .target      (target),
        .pc          (pc),
        .taken       (taken),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
`ifdef PC_TRACE_EN
        ,
        .last_src    (last_src),
        .last_dst    (last_dst)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state as plain integers and a queue.
    int m_pc;
    int m_taken;
    int m_err;
    int m_src;
    int m_dst;
    int m_stack[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock with the given controls.
    task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                              input logic [1:0] cs, input logic ci, input logic cf,
                              input logic zf, input logic [7:0] tg);
        int seq_v;
        int old_pc;
        int c;
        seq_v  = (m_pc + STEP) % 256;
        old_pc = m_pc;
        if (r) begin
            m_pc = RESET_ADDR;
            m_taken = 0;
            m_err = 0;
            m_stack.delete();
            m_src = RESET_ADDR;
            m_dst = RESET_ADDR;
            return;
        end
        m_taken = 0;
        if (!e) return;
        m_pc = seq_v;
        if (o == JMP) begin
            m_pc = tg;
            m_taken = 1;
        end else if (o == JCOND) begin
            c = (cs == 2'd0) ? 1 : (cs == 2'd1) ? int'(cf) : (cs == 2'd2) ? int'(zf) : 0;
            if ((c ^ int'(ci)) != 0) begin
                m_pc = tg;
                m_taken = 1;
            end
        end else if (o == CALL) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back(seq_v);
                m_pc = tg;
                m_taken = 1;
            end else begin
                m_err = 1;
            end
        end else if (o == RET) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
                m_taken = 1;
            end else begin
                m_err = 1;
            end
        end
        if (m_taken != 0) begin
            m_src = old_pc;
            m_dst = m_pc;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    32'(pc),          32'(m_pc));
        check({tag, ".taken"}, 32'(taken),       32'(m_taken));
        check({tag, ".depth"}, 32'(stack_depth), 32'(m_stack.size()));
        check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        check({tag, ".err"},   32'(err),         32'(m_err));
`ifdef PC_TRACE_EN
        check({tag, ".src"},   32'(last_src),    32'(m_src));
        check({tag, ".dst"},   32'(last_dst),    32'(m_dst));
`endif
    endtask

    // Drive one cycle, update the model, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] o,
                        input logic [1:0] cs, input logic ci, input logic cf,
                        input logic zf, input logic [7:0] tg);
        reset = r; en = e; op = o; cond_sel = cs; cond_inv = ci;
        carry_f = cf; zero_f = zf; target = tg;
        model_step(r, e, o, cs, ci, cf, zf, tg);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic go(input string tag, input logic [2:0] o, input logic [7:0] tg);
        step(tag, 1'b0, 1'b1, o, 2'd0, 1'b0, 1'b0, 1'b0, tg);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; op = NEXT; cond_sel = 2'd0; cond_inv = 1'b0;
        carry_f = 1'b0; zero_f = 1'b0; target = 8'h00;
        m_pc = 0; m_taken = 0; m_err = 0; m_src = 0; m_dst = 0;
        #2;

        // Reset state, then four sequential fetches.
        step("rst", 1'b1, 1'b0, NEXT, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst.pc_const", 32'(pc), 32'h0);
        for (int i = 0; i < 4; i++) go("next", NEXT, 8'h00);
        check("next4.pc_const", 32'(pc), 32'h8);

        // Wrap at the top of the address space, then stall.
        go("jmp_fe", JMP, 8'hFE);
        go("wrap", NEXT, 8'h00);
        check("wrap.pc_const", 32'(pc), 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, JMP, 2'd0, 1'b0, 1'b0, 1'b0, 8'h77);
        check("stall.pc_const", 32'(pc), 32'h0);

        // Conditional branch on zero, normal and inverted.
        step("jc_z1", 1'b0, 1'b1, JCOND, 2'd2, 1'b0, 1'b0, 1'b1, 8'h40);
        check("jc_z1.pc_const", 32'(pc), 32'h40);
        step("jc_z0", 1'b0, 1'b1, JCOND, 2'd2, 1'b0, 1'b0, 1'b0, 8'h40);
        check("jc_z0.pc_const", 32'(pc), 32'h42);
        step("jc_inv", 1'b0, 1'b1, JCOND, 2'd2, 1'b1, 1'b0, 1'b0, 8'h40);
        check("jc_inv.pc_const", 32'(pc), 32'h40);
        step("jc_never", 1'b0, 1'b1, JCOND, 2'd3, 1'b0, 1'b1, 1'b1, 8'h10);
        step("jc_carry", 1'b0, 1'b1, JCOND, 2'd1, 1'b0, 1'b1, 1'b0, 8'h10);

        // Nested call / return.
        go("jmp10", JMP, 8'h10);
        go("call80", CALL, 8'h80);
        go("callA0", CALL, 8'hA0);
        go("ret1", RET, 8'h00);
        check("ret1.pc_const", 32'(pc), 32'h82);
        go("ret2", RET, 8'h00);
        check("ret2.pc_const", 32'(pc), 32'h12);

        // Overflow and underflow.
        go("c1", CALL, 8'h20);
        go("c2", CALL, 8'h30);
        go("c3", CALL, 8'h40);
        go("c4", CALL, 8'h50);
        go("c5", CALL, 8'h60);
        check("ovf.pc_const", 32'(pc), 32'h52);
        check("ovf.err_const", 32'(err), 32'h1);
        go("r1", RET, 8'h00);
        check("r1.pc_const", 32'(pc), 32'h42);
        go("r2", RET, 8'h00);
        go("r3", RET, 8'h00);
        go("r4", RET, 8'h00);
        check("r4.pc_const", 32'(pc), 32'h14);
        go("r5", RET, 8'h00);
        check("r5.pc_const", 32'(pc), 32'h16);

        // Reset mid-sequence with a loaded stack and err set.
        go("d1", CALL, 8'h20);
        go("d2", CALL, 8'h30);
        go("d3", CALL, 8'h40);
        step("rst_mid", 1'b1, 1'b1, CALL, 2'd0, 1'b0, 1'b0, 1'b0, 8'h99);
        check("rst_mid.err_const", 32'(err), 32'h0);

        // Redirect trace (exercised in both builds; compared only with trace).
        go("tj06", JMP, 8'h06);
        go("tj30", JMP, 8'h30);
`ifdef PC_TRACE_EN
        check("trace.src_const", 32'(last_src), 32'h06);
        check("trace.dst_const", 32'(last_dst), 32'h30);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 5) != 0),
                 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
